// File: rtl/mul_accumulator.sv
// Burst accumulator placed after the W-bit multiplier: sums products into an ACC_W result and holds it on a valid/ready output.
// Define MUL_ACC_SAT_EN to make the accumulator clamp at all-ones on carry out; otherwise it wraps modulo 2^ACC_W.
module mul_accumulator #(
  parameter int W     = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [ACC_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic             w_accept;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_ovf_next;

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  assign w_accept   = in_valid && in_ready;
  // A new burst always starts from zero, independent of what acc still holds.
  assign w_acc_base = (r_state == S_IDLE) ? '0 : r_acc;
  assign w_sum      = {1'b0, w_acc_base} + {{(ACC_W + 1 - W){1'b0}}, in_data};
  assign w_carry    = w_sum[ACC_W];

`ifdef MUL_ACC_SAT_EN
  // Once clamped, any later nonzero term carries again, so the clamp persists.
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  assign w_count_next = (r_state == S_IDLE) ? CNT_W'(1)
                      : (&r_count)          ? r_count
                      :                       r_count + CNT_W'(1);
  assign w_ovf_next   = ((r_state == S_IDLE) ? 1'b0 : r_ovf) | w_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            w_state_next = in_last ? S_HOLD : S_ACCUM;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clr) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            if (in_last) begin
              r_out_data  <= w_acc_next;
              r_out_count <= w_count_next;
              r_out_ovf   <= w_ovf_next;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: begin
          r_acc   <= '0;
          r_count <= '0;
          r_ovf   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Scoreboard bench for mul_accumulator (ACC_W=17 so overflow is reachable, CNT_W=3 so count saturation is reachable).
module tb_mul_accumulator;

  localparam int W     = 16;
  localparam int ACC_W = 17;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  typedef struct {
    logic [ACC_W-1:0] d;
    logic [CNT_W-1:0] c;
    logic             o;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mul_accumulator #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [ACC_W-1:0] d, input logic [CNT_W-1:0] c, input logic o);
    exp_t e;
    e.d = d;
    e.c = c;
    e.o = o;
    sb.push_back(e);
  endtask

  // Presents one beat and returns 1ns after the edge that accepted it.
  task automatic beat(input logic [W-1:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: in_ready got 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got data=0x%0h with empty scoreboard", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] result data=0x%0h count=%0d ovf=%0d (exp 0x%0h/%0d/%0d)",
                 out_data, out_count, out_ovf, e.d, e.c, e.o);
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_count", 32'(out_count), 32'(e.c));
        chk("out_ovf", 32'(out_ovf), 32'(e.o));
      end
    end
  end

  initial begin
    logic [ACC_W-1:0] ovf_exp;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Dot-product burst, consumer always ready
    out_ready = 1'b1;
    push(17'h10107, 3'd3, 1'b0);
    beat(16'd0, 1'b0);
    beat(16'h01E4, 1'b0);
    beat(16'hFF23, 1'b1);
    chk("dot_valid_rise", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("dot_valid_fall", 32'(out_valid), 32'd0);

    // Backpressure: result held for 5 cycles
    out_ready = 1'b0;
    push(17'h10107, 3'd3, 1'b0);
    beat(16'd0, 1'b0);
    beat(16'h01E4, 1'b0);
    beat(16'hFF23, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_data", 32'(out_data), 32'h10107);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    push(17'd3, 3'd1, 1'b0);
    beat(16'd3, 1'b1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-burst
    beat(16'd5, 1'b0);
    beat(16'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_count", 32'(out_count), 32'd0);
    chk("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(17'd5, 3'd1, 1'b0);
    beat(16'd5, 1'b1);
    @(posedge clk);
    #1;

    // Overflow of the 17-bit accumulator
`ifdef MUL_ACC_SAT_EN
    ovf_exp = 17'h1FFFF;
`else
    ovf_exp = 17'h0FFFD;
`endif
    push(ovf_exp, 3'd3, 1'b1);
    beat(16'hFFFF, 1'b0);
    beat(16'hFFFF, 1'b0);
    beat(16'hFFFF, 1'b1);
    @(posedge clk);
    #1;

    // Abort mid-burst; the beat presented with clr must be dropped
    beat(16'd10, 1'b0);
    beat(16'd20, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd100;
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    push(17'd7, 3'd1, 1'b0);
    beat(16'd7, 1'b1);
    @(posedge clk);
    #1;

    // Abort while holding a result
    out_ready = 1'b0;
    beat(16'd8, 1'b1);
    chk("clr_hold_valid_before", 32'(out_valid), 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_hold_valid_after", 32'(out_valid), 32'd0);
    chk("clr_hold_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Bubbles between beats
    push(17'd4, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(16'd1, (i == 3));
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;

    // Term count saturates at 7 while the sum keeps growing
    push(17'd9, 3'd7, 1'b0);
    for (int i = 0; i < 9; i++) begin
      beat(16'd1, (i == 8));
    end
    @(posedge clk);
    #1;

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_accumulator.md
# mul_accumulator

Sequential accumulator that sits directly downstream of the W-bit `multiplier` and sums a burst of its products into a wider result. It turns the combinational multiplier into a dot-product/MAC datapath. Products arrive over a valid/ready handshake, a burst is terminated by `in_last`, and the result is held on a valid/ready output until consumed.

## Interface
- `W`, 16: width of each incoming product; matches the multiplier `W`.
- `ACC_W`, 32: accumulator/result width; must be ≥ W+1.
- `CNT_W`, 8: width of the term counter.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous abort; discards any partial or held burst.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  W  product from the multiplier, unsigned.
- `in_last`  in  1  beat is the final term of the burst.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  ACC_W  accumulated sum.
- `out_count`  out  CNT_W  number of terms in the burst; saturates at all-ones.
- `out_ovf`  out  1  a carry out of ACC_W occurred during the burst.

## Operation
- Reset values: state IDLE, acc=0, count=0, ovf=0, `out_valid`=0, `out_data`=0, `out_count`=0, `out_ovf`=0. `in_ready`=1 as soon as `rst_n` is high.
- Accept means `in_valid && in_ready`. `in_ready` = (state != HOLD).
- Arithmetic is unsigned. `in_data` is zero-extended to ACC_W+1 bits and added to acc.
  - The carry out of bit ACC_W-1 sets the sticky ovf.
  - The low ACC_W bits are stored (see Configuration for saturation).
- FSM:
  - IDLE: acc=0, count=0. On an accepted beat, acc←in_data and count←1. Go to HOLD if `in_last`, else to ACCUM.
  - ACCUM: on an accepted beat, acc←acc+in_data and count←count+1 (saturating). Go to HOLD if `in_last`. No beat: stay.
  - HOLD: `out_valid`=1, and `out_data`/`out_count`/`out_ovf` stay stable. When `out_ready`=1, go to IDLE: clear acc, count and ovf, and drop `out_valid` next cycle.
- `clr` has priority over everything. The next state is IDLE with acc, count, ovf and `out_valid` cleared, and any beat presented that cycle is dropped.
- `in_last` is ignored unless the beat is accepted.
- Async reset mid-burst or mid-HOLD clears all state immediately; the result is lost.
- Outputs are registered. `out_data`/`out_count`/`out_ovf` are loaded on the transition into HOLD and hold their value until the next HOLD entry or clear.

## Timing
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, so it is visible 1 cycle after that beat.
- Single-beat burst (IDLE with `in_last`) goes straight to HOLD with `out_data`=in_data.
- HOLD lasts at least 1 cycle. The minimum period for an N-term burst is N+1 cycles. No beat is accepted in the cycle `out_ready` is sampled in HOLD.
- `out_valid` never drops without `out_ready`, `clr` or reset.
- The count saturates at 2^CNT_W−1; the accumulation itself continues.

## Configuration
- `MUL_ACC_SAT_EN` defined: on carry out, acc clamps to all-ones (2^ACC_W−1) and stays clamped for the rest of the burst. `out_ovf`=1.
- Not defined: acc wraps modulo 2^ACC_W. `out_ovf`=1 still flags the wrap.
- No other behaviour differs.

## Test plan
- Reset: hold `rst_n`=0 mid-burst after 2 beats. Require all outputs 0 and `in_ready`=1, then a fresh burst of {5, last} yields `out_data`=5, `out_count`=1.
- Dot-product: beats 0, 484 (0x01E4), 65315 (0xFF23, last) with `out_ready`=1. Require `out_data`=65799 (0x10107), `out_count`=3, `out_ovf`=0, and `out_valid` high for exactly 1 cycle, starting the cycle after the last beat.
- Backpressure: same burst with `out_ready`=0 for 5 cycles. Require `out_valid` held, `in_ready`=0, and data stable. Assert `out_ready`: `out_valid` drops next cycle and the next burst starts from 0.
- Overflow, ACC_W=17: beats 0xFFFF ×3 (last on the third). Require `out_ovf`=1. Without `MUL_ACC_SAT_EN`, `out_data`=0x0FFFD; with it, `out_data`=0x1FFFF.
- Abort: send 2 beats, then pulse `clr` together with a valid beat. Require the beat dropped and IDLE entered. Then {7, last} yields `out_data`=7, `out_count`=1. `clr` in HOLD drops `out_valid` next cycle.
- Bubbles: `in_valid` toggles 1/0 across 4 beats of 1 (last on the fourth). Require `out_data`=4 and `out_count`=4.
